// File: rtl/ram_fill_scan_pkg.sv
// Shared definitions for the fill/scan RAM block: controller states and default geometry.
package ram_fill_scan_pkg;

    // Default geometry of the front-panel memory (32 words of 8 bits).
    localparam int unsigned DefDataW = 8;
    localparam int unsigned DefAddrW = 5;

    // Controller states; encodings are fixed so they can be probed on a debug header.
    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StFill     = 2'd1,
        StScan     = 2'd2,
        StScanLast = 2'd3
    } state_e;

endpackage

// File: rtl/ram_fill_scan_if.sv
// Bus bundle between the front panel (master) and the fill/scan RAM (slave).
interface ram_fill_scan_if
    import ram_fill_scan_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned ADDR_W = DefAddrW
);

    logic                     wr_en;
    logic [ADDR_W-1:0]        addr;
    logic [DATA_W-1:0]        din;
    logic                     fill_start;
    logic [DATA_W-1:0]        fill_val;
    logic                     scan_start;
    logic [DATA_W-1:0]        dout;
    logic                     busy;
    logic                     done;
    logic [DATA_W+ADDR_W-1:0] sum;
    logic [ADDR_W-1:0]        cur_addr;

    modport master (
        output wr_en, addr, din, fill_start, fill_val, scan_start,
        input  dout, busy, done, sum, cur_addr
    );

    modport slave (
        input  wr_en, addr, din, fill_start, fill_val, scan_start,
        output dout, busy, done, sum, cur_addr
    );

endinterface

// File: rtl/ram_fill_scan_sync_ram.sv
// Inferred single-port RAM with a registered read port that returns old data on a
// same-address write. Only the output register is reset; the array keeps its contents.
module ram_fill_scan_sync_ram #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [Depth];

    // Array write; no reset so contents survive a board reset.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Registered read; sampling before the write lands gives old-data behaviour.
    always_ff @(posedge clock) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/ram_fill_scan.sv
// Single-port RAM with a controller offering manual access plus FILL (write one value to
// every word) and SCAN (sum every word). The address/data muxes and the FSM live here.
module ram_fill_scan
    import ram_fill_scan_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned ADDR_W = DefAddrW
) (
    input  logic            clock,
    input  logic            reset,
    ram_fill_scan_if.slave  bus
);

    localparam int unsigned    SumW     = DATA_W + ADDR_W;
    localparam logic [ADDR_W-1:0] LastAddr = '1;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_cnt_q, addr_cnt_d;
    logic [DATA_W-1:0]   fill_val_q, fill_val_d;
    logic [SumW-1:0]     sum_q, sum_d;
    logic                done_q, done_d;

    logic                ram_we;
    logic                ram_re;
    logic [ADDR_W-1:0]   ram_addr;
    logic [DATA_W-1:0]   ram_wdata;
    logic [DATA_W-1:0]   ram_rdata;
    logic [SumW-1:0]     rdata_ext;

    assign rdata_ext = {{ADDR_W{1'b0}}, ram_rdata};

    // Next-state, engine counter, accumulator and RAM port muxing.
    always_comb begin
        state_d    = state_q;
        addr_cnt_d = addr_cnt_q;
        fill_val_d = fill_val_q;
        sum_d      = sum_q;
        done_d     = 1'b0;
        ram_we     = 1'b0;
        ram_re     = 1'b0;
        ram_addr   = bus.addr;
        ram_wdata  = bus.din;

        unique case (state_q)
            StIdle: begin
                // Manual port; a start on the same edge still lets the write through.
                ram_we     = bus.wr_en;
                ram_re     = 1'b1;
                addr_cnt_d = '0;
                if (bus.fill_start) begin
                    state_d    = StFill;
                    fill_val_d = bus.fill_val;
                end else if (bus.scan_start) begin
                    state_d = StScan;
                    sum_d   = '0;
                end
            end
            StFill: begin
                ram_we    = 1'b1;
                ram_addr  = addr_cnt_q;
                ram_wdata = fill_val_q;
                if (addr_cnt_q == LastAddr) begin
                    state_d    = StIdle;
                    done_d     = 1'b1;
                    addr_cnt_d = '0;
                end else begin
                    addr_cnt_d = addr_cnt_q + 1'b1;
                end
            end
            StScan: begin
                ram_re   = 1'b1;
                ram_addr = addr_cnt_q;
                // Read data trails the address by one edge; the first edge has nothing yet.
                if (addr_cnt_q != '0) begin
                    sum_d = sum_q + rdata_ext;
                end
                if (addr_cnt_q == LastAddr) begin
                    state_d = StScanLast;
                end else begin
                    addr_cnt_d = addr_cnt_q + 1'b1;
                end
            end
            StScanLast: begin
                // Fold in the last word; dout keeps showing it.
                sum_d      = sum_q + rdata_ext;
                state_d    = StIdle;
                done_d     = 1'b1;
                addr_cnt_d = '0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Reset beats every write source, manual or engine.
        if (reset) begin
            ram_we = 1'b0;
        end
    end

    // Controller state registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            addr_cnt_q <= '0;
            fill_val_q <= '0;
            sum_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_cnt_q <= addr_cnt_d;
            fill_val_q <= fill_val_d;
            sum_q      <= sum_d;
            done_q     <= done_d;
        end
    end

    ram_fill_scan_sync_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clock (clock),
        .reset (reset),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign bus.dout     = ram_rdata;
    assign bus.busy     = (state_q != StIdle);
    assign bus.done     = done_q;
    assign bus.sum      = sum_q;
    assign bus.cur_addr = addr_cnt_q;

endmodule
